hex_ascii_tx_streamer: RTL and testbench

Converts a binary result word into a stream of ASCII hexadecimal characters, most significant nibble first, followed by CR LF. It sits between the calculator datapath and the UART transmitter of the serial hex calculator. It performs the inverse of the receive-side ASCII-to-hex decoding. Byte delivery uses a registered valid/ready handshake so the UART can apply backpressure.

---
 rtl/hex_ascii_tx_streamer.sv | 149 ++++++++++++++
 tb/tb_hex_ascii_tx_streamer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hex_ascii_tx_streamer.sv
// hex_ascii_tx_streamer
// Prints a DATA_W-bit result word as uppercase ASCII hex digits, most
// significant nibble first, followed by CR LF. Bytes leave through a
// registered valid/ready handshake so the UART can stall the stream.
// Optional build macro: HEX_TX_LEADING_ZERO_SUPPRESS_EN -- when defined,
// leading zero digits are skipped (a zero value still prints "0").
module hex_ascii_tx_streamer #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i
);

    localparam int NIB   = DATA_W / 4;
    localparam int CNT_W = $clog2(NIB + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIGIT,
        S_CR,
        S_LF
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] aligned;
    logic [CNT_W-1:0]  load_cnt;
    logic [DATA_W-1:0] shl;
    logic              xfer;

    // Nibble to uppercase ASCII hex character.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

`ifdef HEX_TX_LEADING_ZERO_SUPPRESS_EN
    // Priority-encode the most significant nonzero nibble and pre-align the word to it.
    always_comb begin
        int lz;
        lz = NIB - 1;
        for (int i = 0; i < NIB; i++) begin
            if (data_in_i[4*i +: 4] != 4'h0) begin
                lz = NIB - 1 - i;
            end
        end
        aligned  = data_in_i << (4 * lz);
        load_cnt = CNT_W'(NIB - lz);
    end
`else
    // Every digit is printed, zeros included.
    always_comb begin
        aligned  = data_in_i;
        load_cnt = CNT_W'(NIB);
    end
`endif

    assign xfer = tx_valid_q && tx_ready_i;
    assign shl  = shift_q << 4;

    // Next-state and next-output logic; everything holds unless a byte transfers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    shift_d    = aligned;
                    cnt_d      = load_cnt;
                    tx_data_d  = hex_char(aligned[DATA_W-1 -: 4]);
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (xfer) begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d     = '0;
                        tx_data_d = 8'h0D;
                        state_d   = S_CR;
                    end else begin
                        shift_d   = shl;
                        cnt_d     = cnt_q - CNT_W'(1);
                        tx_data_d = hex_char(shl[DATA_W-1 -: 4]);
                    end
                end
            end
            S_CR: begin
                if (xfer) begin
                    tx_data_d = 8'h0A;
                    state_d   = S_LF;
                end
            end
            S_LF: begin
                if (xfer) begin
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any partial line at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;

endmodule

// File: tb/tb_hex_ascii_tx_streamer.sv
module tb_hex_ascii_tx_streamer;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        start;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks   = 0;
    int failures = 0;
    int busy_cycles;
    logic [7:0] exp_b [0:7];
    int exp_n;

    hex_ascii_tx_streamer #(.DATA_W(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_in_i  (data_in),
        .start_i    (start),
        .busy_o     (busy),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_exp(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] b4, input logic [7:0] b5);
        exp_n = n;
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
        exp_b[3] = b3; exp_b[4] = b4; exp_b[5] = b5;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge. Prints val and checks exp_b.
    // stall: TX_READY low cycles before each byte; noise: keep START high with FFFF.
    task automatic run_line(input logic [15:0] val, input int stall, input bit noise, input string tag);
        start   = 1'b1;
        data_in = val;
        tick();
        start = noise;
        if (noise) data_in = 16'hFFFF;
        check({tag, "_first_busy"}, {62'd0, busy, tx_valid}, 64'd3);
        busy_cycles = 0;
        for (int i = 0; i < exp_n; i++) begin
            for (int s = 0; s < stall; s++) begin
                tx_ready = 1'b0;
                check($sformatf("%s_hold%0d_%0d", tag, i, s), {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, exp_b[i]});
                if (busy) busy_cycles++;
                tick();
            end
            tx_ready = 1'b1;
            check($sformatf("%s_byte%0d", tag, i), {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, exp_b[i]});
            if (busy) busy_cycles++;
            tick();
        end
        tx_ready = 1'b0;
        start    = 1'b0;
        check({tag, "_idle"}, {54'd0, busy, tx_valid, tx_data}, 64'd0);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_n * (stall + 1)));
        tick();
        check({tag, "_still_idle"}, {62'd0, busy, tx_valid}, 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        data_in  = 16'h0000;
        tx_ready = 1'b0;
        tick();
        check("reset_outputs", {54'd0, busy, tx_valid, tx_data}, 64'd0);
        rst = 1'b0;
        tx_ready = 1'b1;
        tick();
        check("idle_no_start", {54'd0, busy, tx_valid, tx_data}, 64'd0);
        tx_ready = 1'b0;

        // 1A2F at full rate, then with three stall cycles per byte.
        set_exp(6, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A);
        run_line(16'h1A2F, 0, 1'b0, "1a2f_fast");
        run_line(16'h1A2F, 3, 1'b0, "1a2f_stall");

        // START with FFFF during the whole line (including the LF edge) is ignored.
        set_exp(6, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A);
        run_line(16'h0001, 0, 1'b1, "0001_noise");

`ifdef HEX_TX_LEADING_ZERO_SUPPRESS_EN
        set_exp(4, 8'h42, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00);
        run_line(16'h00B0, 0, 1'b0, "00b0");
        set_exp(3, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00);
        run_line(16'h0000, 1, 1'b0, "0000");
`else
        set_exp(6, 8'h30, 8'h30, 8'h42, 8'h30, 8'h0D, 8'h0A);
        run_line(16'h00B0, 0, 1'b0, "00b0");
        set_exp(6, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A);
        run_line(16'h0000, 1, 1'b0, "0000");
`endif
        set_exp(6, 8'h38, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A);
        run_line(16'h8000, 0, 1'b0, "8000");
        set_exp(6, 8'h33, 8'h45, 8'h37, 8'h43, 8'h0D, 8'h0A);
        run_line(16'h3E7C, 2, 1'b0, "3e7c");

        // Reset after the second byte of C3D5 abandons the line immediately.
        start   = 1'b1;
        data_in = 16'hC3D5;
        tick();
        start    = 1'b0;
        tx_ready = 1'b1;
        check("c3d5_byte0", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, 8'h43});
        tick();
        check("c3d5_byte1", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, 8'h33});
        tick();
        tx_ready = 1'b0;
        check("c3d5_byte2_held", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, 8'h44});
        #2;
        rst = 1'b1;
        #1;
        check("midline_reset", {54'd0, busy, tx_valid, tx_data}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("after_reset_idle", {54'd0, busy, tx_valid, tx_data}, 64'd0);
        set_exp(6, 8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A);
        run_line(16'h0009, 0, 1'b0, "0009");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
